// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;
    localparam int          DEFAULT_STEP         = 4;

    // Mask that clears the low 'bits' address bits; callers slice to width.
    function automatic logic [63:0] align_mask(input int bits);
        return ~((64'd1 << bits) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch, steering and control signals of the program-counter unit.
interface pc_unit_if #(
    parameter int N = 32
);
    logic         fetch_ready;
    logic         redirect_valid;
    logic [N-1:0] redirect_target;
    logic         trap_valid;
    logic [N-1:0] trap_vector;
    logic         halt_req;
    logic         resume_req;
    logic [N-1:0] instruction_address;
    logic         fetch_valid;
    logic         halted;
    logic         misalign_fault;
    logic [N-1:0] fetch_count;

    modport slave (
        input  fetch_ready, redirect_valid, redirect_target,
               trap_valid, trap_vector, halt_req, resume_req,
        output instruction_address, fetch_valid, halted,
               misalign_fault, fetch_count
    );

    modport master (
        output fetch_ready, redirect_valid, redirect_target,
               trap_valid, trap_vector, halt_req, resume_req,
        input  instruction_address, fetch_valid, halted,
               misalign_fault, fetch_count
    );
endinterface

// File: rtl/pc_unit_register_ar.sv
// N-bit load-enabled register with asynchronous active-high reset to INIT.
module register_ar #(
    parameter int           N    = 32,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] data_q;

    // Hold value unless enabled; reset loads INIT without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_q <= INIT;
        else if (en_i)
            data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with fetch handshake, redirect/trap steering, halt/resume.
//
// state | meaning
// BOOT  | out of reset, no fetch request yet; inputs ignored
// RUN   | fetching; PC steps on each accepted fetch
// HALT  | no fetch request; trap/redirect may still load the PC
module pc_unit
    import pc_pkg::*;
#(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR),
    parameter int           STEP         = DEFAULT_STEP,
    parameter int           ALIGN_BITS   = 2
) (
    input logic       clk,
    input logic       rst,
    pc_unit_if.slave  bus
);

    localparam logic [63:0]  MASK64 = align_mask(ALIGN_BITS);
    localparam logic [N-1:0] MASK   = MASK64[N-1:0];

    pc_state_e    state_q, state_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic         halted_q, halted_d;
    logic         misalign_q, misalign_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] count_q;
    logic         accept;
    logic [N-1:0] trap_aligned;
    logic         target_misaligned;

    assign accept            = fetch_valid_q & bus.fetch_ready;
    assign trap_aligned      = bus.trap_vector & MASK;
    assign target_misaligned = |(bus.redirect_target & ~MASK);

    register_ar #(.N(N), .INIT(RESET_VECTOR)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .en_i (1'b1),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    register_ar #(.N(N), .INIT('0)) u_count (
        .clk  (clk),
        .rst  (rst),
        .en_i (accept),
        .d_i  (count_q + N'(1)),
        .q_o  (count_q)
    );

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

    // Next state, flags and next-PC priority mux (trap > redirect > step > hold).
    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        halted_d      = halted_q;
        misalign_d    = 1'b0;
        pc_d          = pc_q;

        if (state_q == RUN || state_q == HALT) begin
            if (bus.trap_valid) begin
                pc_d = trap_aligned;
            end else if (bus.redirect_valid) begin
                if (target_misaligned) begin
                    pc_d       = trap_aligned;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = bus.redirect_target;
                end
            end else if (state_q == RUN && accept) begin
                pc_d = pc_q + N'(STEP);
            end
        end

        case (state_q)
            BOOT: begin
                state_d       = RUN;
                fetch_valid_d = 1'b1;
                halted_d      = 1'b0;
            end
            RUN: begin
                if (bus.halt_req) begin
                    state_d       = HALT;
                    fetch_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else begin
                    fetch_valid_d = 1'b1;
                    halted_d      = 1'b0;
                end
            end
            HALT: begin
                fetch_valid_d = 1'b0;
                halted_d      = 1'b1;
                if (bus.resume_req) begin
                    state_d       = RUN;
                    fetch_valid_d = 1'b1;
                    halted_d      = 1'b0;
                end
            end
            default: begin
                state_d       = BOOT;
                fetch_valid_d = 1'b0;
                halted_d      = 1'b0;
            end
        endcase
    end

    assign bus.instruction_address = pc_q;
    assign bus.fetch_valid         = fetch_valid_q;
    assign bus.halted              = halted_q;
    assign bus.misalign_fault      = misalign_q;
    assign bus.fetch_count         = count_q;

endmodule
